lap_memory: RTL and testbench
=============================

// Module: lap_memory
// PURPOSE
//  Circular lap-time store between the stopwatch counter and the display output selector.
//  Captures the 12-bit stopwatch time on each lap press and keeps the last DEPTH laps.
//  Presents one stored lap on mem_out, which drives the selector's mem input.
//  A scroll press steps through the stored laps, from oldest to newest, then wraps.
// PARAMETERS
//  WIDTH  12  bit width of one time sample, unsigned binary
//  DEPTH  8   number of lap entries; must be a power of two, >= 2
// PORTS
//  clk       in   1                   system clock
//  nrst      in   1                   synchronous active-low reset
//  time_in   in   WIDTH               live stopwatch time, sampled on lap capture
//  lap       in   1                   lap button level, synchronous to clk
//  next      in   1                   scroll button level, synchronous to clk
//  clear     in   1                   synchronous clear, level, active-high
//  mem_out   out  WIDTH               displayed lap value, registered
//  rd_idx    out  $clog2(DEPTH)       displayed entry position, 0 = oldest
//  count     out  $clog2(DEPTH)+1     number of valid entries, 0..DEPTH
//  full      out  1                   count == DEPTH
//  empty     out  1                   count == 0
// BEHAVIOUR
//  - Reset (nrst low at an edge): entries, wr_ptr, old_ptr, rd_ptr, count, mem_out and rd_idx go to 0.
//    empty=1, full=0. Reset mid-operation discards all laps.
//  - Rising-edge detection: rise = in & ~in_q; in_q is registered every cycle.
//    Action happens at the same edge where the input is first sampled high.
//  - Priority per edge: reset > clear > lap rise > next rise.
//    A next rise in the same cycle as a lap rise is dropped.
//  - clear: count=0; wr/old/rd ptr=0; mem_out=0. Storage array is not wiped. Edge history is still updated.
//  - lap rise: mem[wr_ptr] <= time_in; wr_ptr <= wr_ptr+1 (mod DEPTH); rd_ptr <= wr_ptr (jumps to newest).
//    If count<DEPTH: count++. Else the oldest entry is overwritten and old_ptr++ (mod DEPTH).
//  - next rise with count==0: no-op.
//    Otherwise, if rd_ptr == newest (wr_ptr-1), rd_ptr <= old_ptr. Else rd_ptr <= rd_ptr+1 (mod DEPTH).
//  - mem_out <= (count==0) ? 0 : mem[rd_ptr]. It is registered from the already-updated state.
//    Capture at edge k gives the new value on mem_out after edge k+1 (1-cycle latency).
//  - rd_idx <= (rd_ptr-old_ptr) mod DEPTH, with the same 1-cycle latency.
//    count, full and empty are combinational from count.
//  - All pointer arithmetic wraps naturally at $clog2(DEPTH) bits.
//    time_in is stored unmodified, no saturation.
// CONFIGURATION
//  LAP_MEMORY_SPLIT_EN defined:
//    mem_out shows the split time: mem[rd_ptr] - mem[rd_ptr-1], modulo 2^WIDTH.
//    For the oldest entry it shows mem[old_ptr] unchanged.
//    Latency is still 1 cycle; the subtractor sits before the mem_out register.
//  LAP_MEMORY_SPLIT_EN undefined: mem_out shows absolute stored times, and no subtractor is built.
// STRUCTURE
//  lap_memory_pkg holds:
//    LAP_WIDTH=12, LAP_DEPTH=8
//    typedef logic [LAP_WIDTH-1:0] lap_time_t
//    typedef logic [$clog2(LAP_DEPTH)-1:0] lap_ptr_t
//  One sub-module, lap_rise_detect: 1-bit registered edge detector (clk, nrst, in, rise).
//    It is instantiated twice, once for lap and once for next.
//  Storage is a flat register array; no RAM macro.
// TESTING
//  1 Reset then idle: mem_out=0, count=0, empty=1, full=0, rd_idx=0.
//  2 time_in=12'h005, lap rise; then time_in=12'h00C, lap rise:
//    count=2, mem_out=12'h00C one cycle later, rd_idx=1.
//  3 After test 2, next rise -> mem_out=12'h005, rd_idx=0. Next rise again -> 12'h00C, rd_idx=1.
//  4 Nine laps of 1..9: count=8, full=1, newest=9. Eight next rises visit 2,3,...,9 and wrap; value 1 is never seen.
//  5 lap and next rise in the same cycle with time_in=12'h0AA: the entry is stored and shown.
//    The next rise is ignored (rd_idx = newest). Holding lap high for 5 cycles gives exactly one capture.
//  6 clear during a lap rise: count=0, mem_out=0 next cycle, and no entry is written.
//    With LAP_MEMORY_SPLIT_EN, laps 12'h010 then 12'h018 show 12'h008; after next rise, 12'h010.

Source files
------------

// File: rtl/lap_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lap_memory_pkg
//  Purpose  : Shared widths and types for the lap-time store.
//             LAP_WIDTH : bits per stored time sample (unsigned)
//             LAP_DEPTH : number of lap entries (power of two, >= 2)
//  Revision : 1.0 - initial release
// ============================================================================
package lap_memory_pkg;

    localparam int LAP_WIDTH = 12;
    localparam int LAP_DEPTH = 8;

    typedef logic [LAP_WIDTH-1:0]         lap_time_t;
    typedef logic [$clog2(LAP_DEPTH)-1:0] lap_ptr_t;

endpackage : lap_memory_pkg
`default_nettype wire

// File: rtl/lap_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : lap_rise_detect
//  Purpose  : 1-bit rising-edge detector for a button level that is already
//             synchronous to clk. rise is high in the cycle where the input is
//             first seen high, so the consumer acts on that same edge.
//  Ports    : clk  - system clock
//             nrst - synchronous active-low reset
//             in   - input level
//             rise - in & ~(in delayed by one cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module lap_rise_detect (
    input  logic clk,
    input  logic nrst,
    input  logic in,
    output logic rise
);

    logic r_in_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign rise = in & ~r_in_q;

endmodule : lap_rise_detect
`default_nettype wire

// File: rtl/lap_memory.sv
`default_nettype none
// ============================================================================
//  Module   : lap_memory
//  Purpose  : Circular store of the last DEPTH lap times. A lap press captures
//             time_in, a next press scrolls the displayed entry from oldest to
//             newest and wraps. mem_out / rd_idx are registered from the
//             pointer state of the previous edge (one cycle of latency).
//  Ports    : clk, nrst (sync active-low), time_in, lap, next, clear
//             mem_out (displayed value), rd_idx (0 = oldest),
//             count (valid entries), full, empty
//  Config   : LAP_MEMORY_SPLIT_EN - when defined, mem_out shows the split
//             (difference to the previous lap) instead of the absolute time;
//             the oldest entry is shown unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module lap_memory
    import lap_memory_pkg::*;
#(
    parameter int WIDTH = LAP_WIDTH,
    parameter int DEPTH = LAP_DEPTH
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [WIDTH-1:0]           time_in,
    input  logic                       lap,
    input  logic                       next,
    input  logic                       clear,
    output logic [WIDTH-1:0]           mem_out,
    output logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]     C_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0]   C_ONE   = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_old_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_mem_out;
    logic [PTR_W-1:0] r_rd_idx;

    logic             w_lap_rise;
    logic             w_next_rise;
    logic [PTR_W-1:0] w_newest;
    logic [WIDTH-1:0] w_view;

    lap_rise_detect u_lap_rise (
        .clk  (clk),
        .nrst (nrst),
        .in   (lap),
        .rise (w_lap_rise)
    );

    lap_rise_detect u_next_rise (
        .clk  (clk),
        .nrst (nrst),
        .in   (next),
        .rise (w_next_rise)
    );

    assign w_newest = r_wr_ptr - C_ONE;

`ifdef LAP_MEMORY_SPLIT_EN
    // Split time relative to the preceding lap; the oldest lap has no
    // predecessor in the window, so it is shown as-is.
    logic [PTR_W-1:0] w_prev_ptr;
    assign w_prev_ptr = r_rd_ptr - C_ONE;
    assign w_view     = (r_rd_ptr == r_old_ptr) ? r_mem[r_rd_ptr]
                                                : r_mem[r_rd_ptr] - r_mem[w_prev_ptr];
`else
    assign w_view = r_mem[r_rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_old_ptr <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_mem_out <= '0;
            r_rd_idx  <= '0;
        end else if (clear) begin
            // Storage is left intact; count = 0 makes it invisible.
            r_wr_ptr  <= '0;
            r_old_ptr <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_mem_out <= '0;
            r_rd_idx  <= '0;
        end else begin
            // Display is taken from the state settled at the previous edge.
            r_mem_out <= (r_count == '0) ? '0 : w_view;
            r_rd_idx  <= r_rd_ptr - r_old_ptr;

            if (w_lap_rise) begin
                r_mem[r_wr_ptr] <= time_in;
                r_wr_ptr        <= r_wr_ptr + C_ONE;
                r_rd_ptr        <= r_wr_ptr;
                if (r_count != C_DEPTH) begin
                    r_count <= r_count + (PTR_W+1)'(1);
                end else begin
                    r_old_ptr <= r_old_ptr + C_ONE;
                end
            end else if (w_next_rise && (r_count != '0)) begin
                if (r_rd_ptr == w_newest) begin
                    r_rd_ptr <= r_old_ptr;
                end else begin
                    r_rd_ptr <= r_rd_ptr + C_ONE;
                end
            end
        end
    end

    assign mem_out = r_mem_out;
    assign rd_idx  = r_rd_idx;
    assign count   = r_count;
    assign full    = (r_count == C_DEPTH);
    assign empty   = (r_count == '0);

endmodule : lap_memory
`default_nettype wire

// File: tb/tb_lap_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lap_memory
//  Purpose  : Self-checking bench for lap_memory. A queue-based model holds
//             the laps in age order; the displayed value is derived from the
//             queue position, independent of any pointer arithmetic.
//  Config   : honours LAP_MEMORY_SPLIT_EN in its expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lap_memory;
    import lap_memory_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic [11:0] time_in;
    logic        lap;
    logic        next;
    logic        clear;
    logic [11:0] mem_out;
    logic [2:0]  rd_idx;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int vectors = 0;
    int errors  = 0;

    // Reference model: queue of stored laps, oldest first.
    lap_time_t mq[$];
    int        midx;
    logic [11:0] m_out;
    logic [2:0]  m_idx;
    logic        m_pl, m_pn;

    lap_memory dut (
        .clk     (clk),
        .nrst    (nrst),
        .time_in (time_in),
        .lap     (lap),
        .next    (next),
        .clear   (clear),
        .mem_out (mem_out),
        .rd_idx  (rd_idx),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_view();
        if (mq.size() == 0) return 12'h000;
`ifdef LAP_MEMORY_SPLIT_EN
        if (midx == 0) return mq[0];
        return mq[midx] - mq[midx-1];
`else
        return mq[midx];
`endif
    endfunction

    // Apply one cycle of inputs (called at negedge), advance model at posedge.
    task automatic tick(input logic l, input logic n, input logic c,
                        input logic [11:0] t, input logic r);
        logic lr, nr;
        lap = l; next = n; clear = c; time_in = t; nrst = r;
        @(posedge clk);
        if (!r) begin
            mq.delete(); midx = 0; m_out = '0; m_idx = '0; m_pl = 0; m_pn = 0;
        end else begin
            lr = l & ~m_pl;
            nr = n & ~m_pn;
            m_pl = l;
            m_pn = n;
            if (c) begin
                mq.delete(); midx = 0; m_out = '0; m_idx = '0;
            end else begin
                m_out = model_view();
                m_idx = 3'(midx);
                if (lr) begin
                    mq.push_back(t);
                    if (mq.size() > LAP_DEPTH) void'(mq.pop_front());
                    midx = mq.size() - 1;
                end else if (nr && mq.size() != 0) begin
                    midx = (midx == mq.size() - 1) ? 0 : midx + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 12'h000, 0);
        tick(0, 0, 0, 12'h000, 0);
        tick(0, 0, 0, 12'h000, 1);
    endtask

    task automatic test_reset();
        do_reset();
        tick(0, 0, 0, 12'h000, 1);
        vectors++;
        if ({mem_out, rd_idx, count, full, empty} !== {12'h000, 3'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: mem_out=%h rd_idx=%0d count=%0d full=%b empty=%b, expected 000 0 0 0 1",
                     mem_out, rd_idx, count, full, empty);
        end
    endtask

    task automatic test_basic();
        logic [11:0] e;
        do_reset();
        tick(1, 0, 0, 12'h005, 1);
        tick(0, 0, 0, 12'h005, 1);
        tick(1, 0, 0, 12'h00C, 1);
        tick(0, 0, 0, 12'h00C, 1);
`ifdef LAP_MEMORY_SPLIT_EN
        e = 12'h007;
`else
        e = 12'h00C;
`endif
        vectors++;
        if ({mem_out, rd_idx, count} !== {e, 3'd1, 4'd2}) begin
            errors++;
            $display("FAIL two_laps: mem_out=%h rd_idx=%0d count=%0d, expected %h 1 2", mem_out, rd_idx, count, e);
        end
        tick(0, 1, 0, 12'h000, 1);
        tick(0, 0, 0, 12'h000, 1);
        vectors++;
        if ({mem_out, rd_idx} !== {12'h005, 3'd0}) begin
            errors++;
            $display("FAIL scroll_oldest: mem_out=%h rd_idx=%0d, expected 005 0", mem_out, rd_idx);
        end
        tick(0, 1, 0, 12'h000, 1);
        tick(0, 0, 0, 12'h000, 1);
        vectors++;
        if ({mem_out, rd_idx} !== {e, 3'd1}) begin
            errors++;
            $display("FAIL scroll_wrap: mem_out=%h rd_idx=%0d, expected %h 1", mem_out, rd_idx, e);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] e;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            tick(1, 0, 0, 12'(i), 1);
            tick(0, 0, 0, 12'(i), 1);
        end
`ifdef LAP_MEMORY_SPLIT_EN
        e = 12'h001;
`else
        e = 12'h009;
`endif
        vectors++;
        if ({mem_out, rd_idx, count, full, empty} !== {e, 3'd7, 4'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full_newest: mem_out=%h rd_idx=%0d count=%0d full=%b empty=%b, expected %h 7 8 1 0",
                     mem_out, rd_idx, count, full, empty, e);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0, 12'h000, 1);
            tick(0, 0, 0, 12'h000, 1);
`ifdef LAP_MEMORY_SPLIT_EN
            e = (i == 0) ? 12'h002 : 12'h001;
`else
            e = 12'(i + 2);
`endif
            vectors++;
            if ({mem_out, rd_idx} !== {e, 3'(i)}) begin
                errors++;
                $display("FAIL wrap_scroll[%0d]: mem_out=%h rd_idx=%0d, expected %h %0d", i, mem_out, rd_idx, e, i);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] e;
        do_reset();
        tick(1, 0, 0, 12'h011, 1);
        tick(0, 0, 0, 12'h011, 1);
        tick(1, 1, 0, 12'h0AA, 1);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 12'h0BB, 1);
        tick(0, 0, 0, 12'h0CC, 1);
`ifdef LAP_MEMORY_SPLIT_EN
        e = 12'h099;
`else
        e = 12'h0AA;
`endif
        vectors++;
        if ({mem_out, rd_idx, count} !== {e, 3'd1, 4'd2}) begin
            errors++;
            $display("FAIL lap_next_same: mem_out=%h rd_idx=%0d count=%0d, expected %h 1 2", mem_out, rd_idx, count, e);
        end
    endtask

    task automatic test_clear();
        logic [11:0] e;
        do_reset();
        tick(1, 0, 0, 12'h033, 1);
        tick(0, 0, 0, 12'h033, 1);
        tick(1, 0, 1, 12'h044, 1);
        tick(0, 0, 0, 12'h044, 1);
        vectors++;
        if ({mem_out, count, full, empty} !== {12'h000, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL clear_lap: mem_out=%h count=%0d full=%b empty=%b, expected 000 0 0 1",
                     mem_out, count, full, empty);
        end
        tick(0, 0, 0, 12'h000, 1);
        vectors++;
        if ({mem_out, rd_idx, count} !== {12'h000, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL clear_idle: mem_out=%h rd_idx=%0d count=%0d, expected 000 0 0", mem_out, rd_idx, count);
        end
        tick(1, 0, 0, 12'h055, 1);
        tick(0, 0, 0, 12'h055, 1);
        vectors++;
        if ({mem_out, rd_idx, count} !== {12'h055, 3'd0, 4'd1}) begin
            errors++;
            $display("FAIL after_clear: mem_out=%h rd_idx=%0d count=%0d, expected 055 0 1", mem_out, rd_idx, count);
        end
        tick(0, 0, 1, 12'h000, 1);
        tick(1, 0, 0, 12'h010, 1);
        tick(0, 0, 0, 12'h010, 1);
        tick(1, 0, 0, 12'h018, 1);
        tick(0, 0, 0, 12'h018, 1);
`ifdef LAP_MEMORY_SPLIT_EN
        e = 12'h008;
`else
        e = 12'h018;
`endif
        vectors++;
        if (mem_out !== e) begin
            errors++;
            $display("FAIL split_pair: mem_out=%h, expected %h", mem_out, e);
        end
        tick(0, 1, 0, 12'h000, 1);
        tick(0, 0, 0, 12'h000, 1);
        vectors++;
        if (mem_out !== 12'h010) begin
            errors++;
            $display("FAIL split_oldest: mem_out=%h, expected 010", mem_out);
        end
    endtask

    task automatic test_random();
        logic l, n, c, r;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            l = ($urandom_range(0, 2) == 0);
            n = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 59) == 0);
            r = (cyc != 300);
            tick(l, n, c, 12'($urandom), r);
            vectors++;
            if ({mem_out, rd_idx, count, full, empty} !==
                {m_out, m_idx, 4'(mq.size()), (mq.size() == LAP_DEPTH), (mq.size() == 0)}) begin
                errors++;
                $display("FAIL random[%0d]: mem_out=%h rd_idx=%0d count=%0d full=%b empty=%b, expected %h %0d %0d",
                         cyc, mem_out, rd_idx, count, full, empty, m_out, m_idx, mq.size());
            end
        end
    endtask

    initial begin
        nrst = 1'b0; lap = 1'b0; next = 1'b0; clear = 1'b0; time_in = '0;
        midx = 0; m_out = '0; m_idx = '0; m_pl = 1'b0; m_pn = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_simultaneous();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_lap_memory
`default_nettype wire
